// File: rtl/vector_exec_pkg.sv
// Shared types and constants for the vector execute sequencer and its helpers.
package vector_exec_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } seq_state_t;

   localparam int NZ_N = 0;
   localparam int NZ_Z = 1;

   localparam int OP_WIDTH_DEFAULT = 3;

   // Counter width for a pass count; a single-pass configuration still needs one bit.
   function automatic int pass_width(input int passes);
      return (passes > 1) ? $clog2(passes) : 1;
   endfunction

endpackage

// File: rtl/nz_flag_accumulator.sv
// Merges per-lane negative/zero flags over all passes of one vector operation.
module nz_flag_accumulator #(
   parameter int laneCount = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 enable,
   input  logic [laneCount-1:0] lane_neg,
   input  logic [laneCount-1:0] lane_zero,
   output logic                 neg_acc,
   output logic                 zero_acc
);

   logic neg_reg;
   logic zero_reg;

   // Clear seeds the identities of OR (negative) and AND (zero).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         neg_reg  <= 1'b0;
         zero_reg <= 1'b1;
      end else if (clear) begin
         neg_reg  <= 1'b0;
         zero_reg <= 1'b1;
      end else if (enable) begin
         neg_reg  <= neg_reg | (|lane_neg);
         zero_reg <= zero_reg & (&lane_zero);
      end
   end

   assign neg_acc  = neg_reg;
   assign zero_acc = zero_reg;

endmodule

// File: rtl/vector_execute_sequencer.sv
// Runs a full-width vector operand pair through a narrower lane ALU array, one
// slice per cycle, assembles the result and commits merged NZ flags on hand-off.
module vector_execute_sequencer
   import vector_exec_pkg::*;
#(
   parameter int registerSize = 8,
   parameter int vectorSize   = 16,
   parameter int laneCount    = 4,
   parameter int opWidth      = OP_WIDTH_DEFAULT
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic                                    start_valid,
   output logic                                    start_ready,
   input  logic [opWidth-1:0]                      op,
   input  logic                                    overwriteFlags,
   input  logic [vectorSize-1:0][registerSize-1:0] vect1,
   input  logic [vectorSize-1:0][registerSize-1:0] vect2,
   output logic [opWidth-1:0]                      alu_op,
   output logic [laneCount-1:0][registerSize-1:0]  lane_a,
   output logic [laneCount-1:0][registerSize-1:0]  lane_b,
   input  logic [laneCount-1:0][registerSize-1:0]  lane_result,
   input  logic [laneCount-1:0]                    lane_neg,
   input  logic [laneCount-1:0]                    lane_zero,
   output logic                                    result_valid,
   input  logic                                    result_ready,
   output logic [vectorSize-1:0][registerSize-1:0] vect_out,
   output logic [1:0]                              NZ_flags,
   output logic                                    busy
);

   localparam int P  = vectorSize / laneCount;
   localparam int PW = pass_width(P);
   localparam logic [PW-1:0] LAST_PASS = PW'(P - 1);

   typedef logic [laneCount-1:0][registerSize-1:0] slice_t;

   seq_state_t state_reg;
   seq_state_t state_next;
   logic [PW-1:0] pass_reg;
   logic [PW-1:0] pass_next;

   logic [vectorSize-1:0][registerSize-1:0] vect1_reg;
   logic [vectorSize-1:0][registerSize-1:0] vect2_reg;
   logic [opWidth-1:0] op_reg;
   logic overwrite_reg;
   logic [1:0] nz_reg;

   slice_t out_slice_reg [P];
   slice_t a_slice [P];
   slice_t b_slice [P];

   logic accept;
   logic run_en;
   logic commit;
   logic neg_acc;
   logic zero_acc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         pass_reg  <= '0;
      end else begin
         state_reg <= state_next;
         pass_reg  <= pass_next;
      end
   end

   // The pass counter parks on the last slice during DONE and is cleared on accept.
   always_comb begin
      state_next   = state_reg;
      pass_next    = pass_reg;
      accept       = 1'b0;
      run_en       = 1'b0;
      commit       = 1'b0;
      start_ready  = 1'b0;
      result_valid = 1'b0;
      busy         = 1'b1;
      unique case (state_reg)
         IDLE: begin
            start_ready = 1'b1;
            busy        = 1'b0;
            if (start_valid) begin
               accept     = 1'b1;
               pass_next  = '0;
               state_next = RUN;
            end
         end
         RUN: begin
            run_en = 1'b1;
            if (pass_reg == LAST_PASS) begin
               state_next = DONE;
            end else begin
               pass_next = pass_reg + PW'(1);
            end
         end
         DONE: begin
            result_valid = 1'b1;
            if (result_ready) begin
               commit     = 1'b1;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vect1_reg     <= '0;
         vect2_reg     <= '0;
         op_reg        <= '0;
         overwrite_reg <= 1'b0;
      end else if (accept) begin
         vect1_reg     <= vect1;
         vect2_reg     <= vect2;
         op_reg        <= op;
         overwrite_reg <= overwriteFlags;
      end
   end

   for (genvar gi = 0; gi < P; gi++) begin : g_slice
      assign a_slice[gi] = vect1_reg[gi*laneCount +: laneCount];
      assign b_slice[gi] = vect2_reg[gi*laneCount +: laneCount];
      assign vect_out[gi*laneCount +: laneCount] = out_slice_reg[gi];
   end

   // Lane operands are forced to zero whenever no slice is in flight.
   always_comb begin
      lane_a = '0;
      lane_b = '0;
      alu_op = '0;
      if (run_en) begin
         lane_a = a_slice[pass_reg];
         lane_b = b_slice[pass_reg];
         alu_op = op_reg;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < P; s++) begin
            out_slice_reg[s] <= '0;
         end
      end else if (run_en) begin
         out_slice_reg[pass_reg] <= lane_result;
      end
   end

   nz_flag_accumulator #(
      .laneCount(laneCount)
   ) u_nz_acc (
      .clk      (clk),
      .reset    (reset),
      .clear    (accept),
      .enable   (run_en),
      .lane_neg (lane_neg),
      .lane_zero(lane_zero),
      .neg_acc  (neg_acc),
      .zero_acc (zero_acc)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         nz_reg <= 2'b00;
      end else if (commit && overwrite_reg) begin
         nz_reg[NZ_N] <= neg_acc;
         nz_reg[NZ_Z] <= zero_acc;
      end
   end

   assign NZ_flags = nz_reg;

endmodule

// File: tb/tb_vector_execute_sequencer.sv
// Self-checking bench: lane ALU stand-in plus an element-wise reference model of
// whole-vector results and NZ flags, driven with directed and random requests.
module tb_vector_execute_sequencer;

   localparam int RS = 8;
   localparam int VS = 16;
   localparam int LC = 4;
   localparam int OW = 3;

   typedef logic [VS-1:0][RS-1:0] vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;
   logic start_valid;
   logic start_ready;
   logic [OW-1:0] op;
   logic overwriteFlags;
   vec_t vect1;
   vec_t vect2;
   logic [OW-1:0] alu_op;
   logic [LC-1:0][RS-1:0] lane_a;
   logic [LC-1:0][RS-1:0] lane_b;
   logic [LC-1:0][RS-1:0] lane_result;
   logic [LC-1:0] lane_neg;
   logic [LC-1:0] lane_zero;
   logic result_valid;
   logic result_ready;
   vec_t vect_out;
   logic [1:0] NZ_flags;
   logic busy;

   logic start_valid1;
   logic start_ready1;
   logic [OW-1:0] alu_op1;
   logic [VS-1:0][RS-1:0] lane_a1;
   logic [VS-1:0][RS-1:0] lane_b1;
   logic [VS-1:0][RS-1:0] lane_result1;
   logic [VS-1:0] lane_neg1;
   logic [VS-1:0] lane_zero1;
   logic result_valid1;
   logic result_ready1;
   vec_t vect_out1;
   logic [1:0] NZ_flags1;
   logic busy1;

   int n_cmp = 0;
   int n_bad = 0;
   logic [1:0] exp_nz;

   vector_execute_sequencer #(
      .registerSize(RS), .vectorSize(VS), .laneCount(LC), .opWidth(OW)
   ) dut (
      .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(start_ready),
      .op(op), .overwriteFlags(overwriteFlags), .vect1(vect1), .vect2(vect2),
      .alu_op(alu_op), .lane_a(lane_a), .lane_b(lane_b), .lane_result(lane_result),
      .lane_neg(lane_neg), .lane_zero(lane_zero), .result_valid(result_valid),
      .result_ready(result_ready), .vect_out(vect_out), .NZ_flags(NZ_flags), .busy(busy)
   );

   vector_execute_sequencer #(
      .registerSize(RS), .vectorSize(VS), .laneCount(VS), .opWidth(OW)
   ) dut_p1 (
      .clk(clk), .reset(reset), .start_valid(start_valid1), .start_ready(start_ready1),
      .op(op), .overwriteFlags(overwriteFlags), .vect1(vect1), .vect2(vect2),
      .alu_op(alu_op1), .lane_a(lane_a1), .lane_b(lane_b1), .lane_result(lane_result1),
      .lane_neg(lane_neg1), .lane_zero(lane_zero1), .result_valid(result_valid1),
      .result_ready(result_ready1), .vect_out(vect_out1), .NZ_flags(NZ_flags1), .busy(busy1)
   );

   function automatic logic [RS-1:0] alu_fn(input logic [OW-1:0] f, input logic [RS-1:0] a,
                                            input logic [RS-1:0] b);
      case (f)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         default: return a;
      endcase
   endfunction

   always_comb begin
      for (int i = 0; i < LC; i++) begin
         lane_result[i] = alu_fn(alu_op, lane_a[i], lane_b[i]);
      end
   end

   always_comb begin
      for (int i = 0; i < LC; i++) begin
         lane_neg[i]  = lane_result[i][RS-1];
         lane_zero[i] = (lane_result[i] == '0);
      end
   end

   always_comb begin
      for (int i = 0; i < VS; i++) begin
         lane_result1[i] = alu_fn(alu_op1, lane_a1[i], lane_b1[i]);
      end
   end

   always_comb begin
      for (int i = 0; i < VS; i++) begin
         lane_neg1[i]  = lane_result1[i][RS-1];
         lane_zero1[i] = (lane_result1[i] == '0);
      end
   end

   // Reference: whole-vector element-wise arithmetic on plain integers.
   function automatic vec_t model_vec(input logic [OW-1:0] f, input vec_t a, input vec_t b);
      vec_t r;
      int x;
      int y;
      int z;
      for (int e = 0; e < VS; e++) begin
         x = int'(a[e]);
         y = int'(b[e]);
         case (f)
            3'd0:    z = (x + y) % 256;
            3'd1:    z = (x - y + 256) % 256;
            3'd2:    z = x & y;
            3'd3:    z = x | y;
            3'd4:    z = x ^ y;
            default: z = x;
         endcase
         r[e] = RS'(z);
      end
      return r;
   endfunction

   // Returns {Z, N}: Z = every element zero, N = any element negative.
   function automatic logic [1:0] model_nz(input vec_t r);
      logic n;
      logic z;
      n = 1'b0;
      z = 1'b1;
      for (int e = 0; e < VS; e++) begin
         if (r[e] >= 8'd128) n = 1'b1;
         if (r[e] != 8'd0) z = 1'b0;
      end
      return {z, n};
   endfunction

   function automatic vec_t fill_vec(input logic [RS-1:0] v);
      vec_t r;
      for (int e = 0; e < VS; e++) r[e] = v;
      return r;
   endfunction

   function automatic vec_t rand_vec();
      vec_t r;
      for (int e = 0; e < VS; e++) r[e] = RS'($urandom);
      return r;
   endfunction

   task automatic issue(input logic [OW-1:0] f, input vec_t a, input vec_t b, input logic ow);
      @(negedge clk);
      op = f;
      vect1 = a;
      vect2 = b;
      overwriteFlags = ow;
      start_valid = 1'b1;
      @(posedge clk);
      #1;
      start_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = -1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (result_valid === 1'b1) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start_valid = 1'b0;
      start_valid1 = 1'b0;
      result_ready = 1'b1;
      result_ready1 = 1'b1;
      op = '0;
      overwriteFlags = 1'b0;
      vect1 = '0;
      vect2 = '0;
      exp_nz = 2'b00;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      $display("txn reset");
      n_cmp++; if (start_ready !== 1'b1) begin n_bad++; $display("FAIL reset_start_ready: got %b want 1", start_ready); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (result_valid !== 1'b0) begin n_bad++; $display("FAIL reset_result_valid: got %b want 0", result_valid); end
      n_cmp++; if (vect_out !== '0) begin n_bad++; $display("FAIL reset_vect_out: got %h want 0", vect_out); end
      n_cmp++; if (NZ_flags !== 2'b00) begin n_bad++; $display("FAIL reset_nz: got %b want 00", NZ_flags); end
      n_cmp++; if ({alu_op, lane_a, lane_b} !== '0) begin n_bad++; $display("FAIL reset_lanes: got %h/%h/%h want 0", alu_op, lane_a, lane_b); end
      n_cmp++; if ({busy1, NZ_flags1, vect_out1} !== '0) begin n_bad++; $display("FAIL reset_p1: got %b/%b/%h want 0", busy1, NZ_flags1, vect_out1); end
   endtask

   task automatic test_add();
      vec_t a;
      vec_t b;
      int lat;
      int low;
      a = fill_vec(8'd1);
      b = fill_vec(8'd2);
      result_ready = 1'b1;
      issue(3'd0, a, b, 1'b1);
      n_cmp++; if (alu_op !== 3'd0) begin n_bad++; $display("FAIL add_alu_op: got %0d want 0", alu_op); end
      n_cmp++; if (lane_a !== a[0 +: LC]) begin n_bad++; $display("FAIL add_lane_a: got %h want %h", lane_a, a[0 +: LC]); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL add_busy: got %b want 1", busy); end
      lat = -1;
      low = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (result_valid === 1'b1 && lat < 0) lat = c;
         if (start_ready === 1'b1) break;
         low++;
      end
      $display("txn add lat=%0d low=%0d out=%h nz=%b", lat, low, vect_out, NZ_flags);
      n_cmp++; if (lat != 5) begin n_bad++; $display("FAIL add_latency: got %0d want 5", lat); end
      n_cmp++; if (low != 5) begin n_bad++; $display("FAIL add_ready_low: got %0d want 5", low); end
      n_cmp++; if (vect_out !== fill_vec(8'd3)) begin n_bad++; $display("FAIL add_vect_out: got %h want all 03", vect_out); end
      n_cmp++; if (NZ_flags !== 2'b00) begin n_bad++; $display("FAIL add_nz: got %b want 00", NZ_flags); end
      exp_nz = 2'b00;
   endtask

   task automatic test_sub_flags();
      vec_t a;
      vec_t b;
      vec_t e;
      int lat;
      a = fill_vec(8'd7);
      b = fill_vec(8'd7);
      issue(3'd1, a, b, 1'b1);
      wait_valid(lat);
      n_cmp++; if (vect_out !== '0) begin n_bad++; $display("FAIL sub_zero_vect: got %h want 0", vect_out); end
      @(posedge clk);
      #1;
      $display("txn sub_zero lat=%0d nz=%b", lat, NZ_flags);
      n_cmp++; if (NZ_flags !== 2'b10) begin n_bad++; $display("FAIL sub_zero_nz: got %b want 10", NZ_flags); end
      a[13] = 8'd6;
      e = '0;
      e[13] = 8'hFF;
      issue(3'd1, a, b, 1'b1);
      wait_valid(lat);
      n_cmp++; if (vect_out !== e) begin n_bad++; $display("FAIL sub_neg_vect: got %h want %h", vect_out, e); end
      @(posedge clk);
      #1;
      $display("txn sub_neg lat=%0d nz=%b", lat, NZ_flags);
      n_cmp++; if (NZ_flags !== 2'b01) begin n_bad++; $display("FAIL sub_neg_nz: got %b want 01", NZ_flags); end
      exp_nz = 2'b01;
   endtask

   task automatic test_no_overwrite();
      int lat;
      issue(3'd1, fill_vec(8'd7), fill_vec(8'd7), 1'b1);
      wait_valid(lat);
      @(posedge clk);
      #1;
      n_cmp++; if (NZ_flags !== 2'b10) begin n_bad++; $display("FAIL noov_setup_nz: got %b want 10", NZ_flags); end
      issue(3'd1, fill_vec(8'd1), fill_vec(8'd2), 1'b0);
      wait_valid(lat);
      @(posedge clk);
      #1;
      $display("txn no_overwrite lat=%0d out=%h nz=%b", lat, vect_out, NZ_flags);
      n_cmp++; if (vect_out !== fill_vec(8'hFF)) begin n_bad++; $display("FAIL noov_vect: got %h want all ff", vect_out); end
      n_cmp++; if (NZ_flags !== 2'b10) begin n_bad++; $display("FAIL noov_nz: got %b want 10", NZ_flags); end
      exp_nz = 2'b10;
   endtask

   task automatic test_stall();
      vec_t a;
      vec_t b;
      vec_t e;
      int lat;
      a = fill_vec(8'd1);
      b = fill_vec(8'd2);
      e = model_vec(3'd1, a, b);
      result_ready = 1'b0;
      issue(3'd1, a, b, 1'b1);
      wait_valid(lat);
      n_cmp++; if (lat != 5) begin n_bad++; $display("FAIL stall_latency: got %0d want 5", lat); end
      for (int c = 0; c < 10; c++) begin
         if (c == 3) begin
            vect1 = fill_vec(8'd5);
            vect2 = fill_vec(8'd5);
            op = 3'd0;
            start_valid = 1'b1;
         end
         if (c == 5) start_valid = 1'b0;
         n_cmp++; if (result_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid c%0d: got %b want 1", c, result_valid); end
         n_cmp++; if (NZ_flags !== exp_nz) begin n_bad++; $display("FAIL stall_nz c%0d: got %b want %b", c, NZ_flags, exp_nz); end
         n_cmp++; if (vect_out !== e) begin n_bad++; $display("FAIL stall_vect c%0d: got %h want %h", c, vect_out, e); end
         @(negedge clk);
      end
      start_valid = 1'b0;
      result_ready = 1'b1;
      @(posedge clk);
      #1;
      exp_nz = model_nz(e);
      $display("txn stall nz=%b", NZ_flags);
      n_cmp++; if (NZ_flags !== exp_nz) begin n_bad++; $display("FAIL stall_commit_nz: got %b want %b", NZ_flags, exp_nz); end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL stall_no_queue c%0d: busy %b want 0", c, busy); end
      end
      n_cmp++; if (vect_out !== e) begin n_bad++; $display("FAIL stall_retain: got %h want %h", vect_out, e); end
   endtask

   task automatic test_reset_mid_run();
      vec_t a;
      vec_t b;
      int lat;
      issue(3'd0, rand_vec(), rand_vec(), 1'b1);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      $display("txn reset_mid_run busy=%b nz=%b", busy, NZ_flags);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
      n_cmp++; if (NZ_flags !== 2'b00) begin n_bad++; $display("FAIL midrst_nz: got %b want 00", NZ_flags); end
      n_cmp++; if (vect_out !== '0) begin n_bad++; $display("FAIL midrst_vect: got %h want 0", vect_out); end
      n_cmp++; if ({start_ready, result_valid} !== 2'b10) begin n_bad++; $display("FAIL midrst_hs: got %b want 10", {start_ready, result_valid}); end
      n_cmp++; if ({alu_op, lane_a, lane_b} !== '0) begin n_bad++; $display("FAIL midrst_lanes: got %h/%h want 0", lane_a, lane_b); end
      @(negedge clk);
      reset = 1'b0;
      exp_nz = 2'b00;
      a = rand_vec();
      b = rand_vec();
      issue(3'd4, a, b, 1'b1);
      wait_valid(lat);
      n_cmp++; if (lat != 5) begin n_bad++; $display("FAIL midrst_after_lat: got %0d want 5", lat); end
      n_cmp++; if (vect_out !== model_vec(3'd4, a, b)) begin n_bad++; $display("FAIL midrst_after_vect: got %h want %h", vect_out, model_vec(3'd4, a, b)); end
      @(posedge clk);
      #1;
      exp_nz = model_nz(model_vec(3'd4, a, b));
      n_cmp++; if (NZ_flags !== exp_nz) begin n_bad++; $display("FAIL midrst_after_nz: got %b want %b", NZ_flags, exp_nz); end
   endtask

   task automatic test_back_to_back();
      int acc_cyc[$];
      vec_t expq[$];
      logic owq[$];
      vec_t a;
      vec_t b;
      logic [OW-1:0] f;
      logic ow;
      int k;
      int cyc;
      int got;
      logic take;
      k = 0;
      cyc = 0;
      got = 0;
      result_ready = 1'b1;
      f = OW'($urandom_range(0, 4));
      a = rand_vec();
      b = rand_vec();
      ow = 1'($urandom_range(0, 1));
      op = f; vect1 = a; vect2 = b; overwriteFlags = ow;
      start_valid = 1'b1;
      while ((k < 3 || expq.size() > 0) && cyc < 80) begin
         @(negedge clk);
         cyc++;
         take = 1'b0;
         if (result_valid === 1'b1) begin
            n_cmp++;
            if (expq.size() == 0) begin
               n_bad++;
               $display("FAIL b2b_extra_result: got %h want none", vect_out);
            end else begin
               if (vect_out !== expq[0]) begin n_bad++; $display("FAIL b2b_vect %0d: got %h want %h", got, vect_out, expq[0]); end
               if (owq[0]) exp_nz = model_nz(expq[0]);
               void'(expq.pop_front());
               void'(owq.pop_front());
               got++;
            end
         end
         if (start_ready === 1'b1 && start_valid === 1'b1) begin
            take = 1'b1;
            acc_cyc.push_back(cyc);
            expq.push_back(model_vec(f, a, b));
            owq.push_back(ow);
            k++;
            $display("txn b2b accept %0d cyc=%0d op=%0d ow=%0b", k, cyc, f, ow);
         end
         @(posedge clk);
         #1;
         if (take) begin
            if (k < 3) begin
               f = OW'($urandom_range(0, 4));
               a = rand_vec();
               b = ($urandom_range(0, 2) == 0) ? a : rand_vec();
               ow = 1'($urandom_range(0, 1));
               op = f; vect1 = a; vect2 = b; overwriteFlags = ow;
            end else begin
               start_valid = 1'b0;
            end
         end
      end
      start_valid = 1'b0;
      n_cmp++; if (got != 3) begin n_bad++; $display("FAIL b2b_results: got %0d want 3", got); end
      n_cmp++;
      if (acc_cyc.size() != 3) begin
         n_bad++;
         $display("FAIL b2b_accepts: got %0d want 3", acc_cyc.size());
      end else begin
         if (acc_cyc[1] - acc_cyc[0] != 6) begin n_bad++; $display("FAIL b2b_spacing0: got %0d want 6", acc_cyc[1] - acc_cyc[0]); end
         n_cmp++;
         if (acc_cyc[2] - acc_cyc[1] != 6) begin n_bad++; $display("FAIL b2b_spacing1: got %0d want 6", acc_cyc[2] - acc_cyc[1]); end
      end
      n_cmp++; if (NZ_flags !== exp_nz) begin n_bad++; $display("FAIL b2b_nz: got %b want %b", NZ_flags, exp_nz); end
   endtask

   task automatic test_p1();
      vec_t a;
      vec_t b;
      vec_t e;
      int lat;
      a = rand_vec();
      b = rand_vec();
      e = model_vec(3'd1, a, b);
      @(negedge clk);
      op = 3'd1; vect1 = a; vect2 = b; overwriteFlags = 1'b1;
      start_valid1 = 1'b1;
      @(posedge clk);
      #1;
      start_valid1 = 1'b0;
      n_cmp++; if (busy1 !== 1'b1) begin n_bad++; $display("FAIL p1_busy: got %b want 1", busy1); end
      lat = -1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (result_valid1 === 1'b1) begin
            lat = c;
            break;
         end
      end
      $display("txn p1 lat=%0d out=%h", lat, vect_out1);
      n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL p1_latency: got %0d want 2", lat); end
      n_cmp++; if (vect_out1 !== e) begin n_bad++; $display("FAIL p1_vect: got %h want %h", vect_out1, e); end
      @(posedge clk);
      #1;
      n_cmp++; if (NZ_flags1 !== model_nz(e)) begin n_bad++; $display("FAIL p1_nz: got %b want %b", NZ_flags1, model_nz(e)); end
   endtask

   task automatic test_random();
      vec_t a;
      vec_t b;
      vec_t e;
      logic [OW-1:0] f;
      logic ow;
      int lat;
      int d;
      for (int t = 0; t < 12; t++) begin
         f = OW'($urandom_range(0, 4));
         a = rand_vec();
         b = ($urandom_range(0, 2) == 0) ? a : rand_vec();
         ow = 1'($urandom_range(0, 1));
         d = $urandom_range(0, 3);
         e = model_vec(f, a, b);
         result_ready = (d == 0);
         issue(f, a, b, ow);
         wait_valid(lat);
         n_cmp++; if (lat != 5) begin n_bad++; $display("FAIL rnd%0d_latency: got %0d want 5", t, lat); end
         for (int c = 0; c < d; c++) begin
            @(negedge clk);
            n_cmp++; if (result_valid !== 1'b1) begin n_bad++; $display("FAIL rnd%0d_hold: got %b want 1", t, result_valid); end
         end
         n_cmp++; if (vect_out !== e) begin n_bad++; $display("FAIL rnd%0d_vect: got %h want %h", t, vect_out, e); end
         result_ready = 1'b1;
         @(posedge clk);
         #1;
         if (ow) exp_nz = model_nz(e);
         $display("txn rnd %0d op=%0d ow=%0b wait=%0d nz=%b", t, f, ow, d, NZ_flags);
         n_cmp++; if (NZ_flags !== exp_nz) begin n_bad++; $display("FAIL rnd%0d_nz: got %b want %b", t, NZ_flags, exp_nz); end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub_flags();
      test_no_overwrite();
      test_stall();
      test_reset_mid_run();
      test_back_to_back();
      test_p1();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/vector_execute_sequencer.md
# vector_execute_sequencer

Multi-cycle controller that runs a long vector operand pair through a narrower array of lane ALUs, one slice per cycle. It sits between decode/operand fetch and the lane ALU array. It latches a full-width request, feeds `laneCount` elements per cycle to the ALUs, and collects their results into a full-width output buffer. It merges per-lane negative/zero flags across all passes and commits them to the architectural NZ flag register when the result is handed off.

## Interface
Parameters:
- `registerSize`, 8: element width in bits
- `vectorSize`, 16: elements per full vector; must be a multiple of `laneCount`
- `laneCount`, 4: ALU lanes available per cycle; `P = vectorSize/laneCount` passes
- `opWidth`, 3: ALU operation select width

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `start_valid`  in  1  request present
- `start_ready`  out  1  sequencer can accept a request
- `op`  in  opWidth  ALU operation for the request
- `overwriteFlags`  in  1  request updates NZ flags on completion
- `vect1`, `vect2`  in  [vectorSize][registerSize]  operand vectors
- `alu_op`  out  opWidth  operation driven to the lane ALUs
- `lane_a`, `lane_b`  out  [laneCount][registerSize]  current slice operands
- `lane_result`  in  [laneCount][registerSize]  combinational ALU results for the current slice
- `lane_neg`, `lane_zero`  in  laneCount  per-lane flags for the current slice
- `result_valid`  out  1  `vect_out` holds a complete result
- `result_ready`  in  1  consumer accepts the result
- `vect_out`  out  [vectorSize][registerSize]  assembled result buffer
- `NZ_flags`  out  2  bit0 = N, bit1 = Z; architectural flag register
- `busy`  out  1  state != IDLE

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `start_ready`=1.
  - On `start_valid`: latch `vect1`, `vect2`, `op`, `overwriteFlags`.
  - Clear the pass counter to 0, set the accumulators to neg_acc=0 and zero_acc=1, then go to RUN.
- RUN:
  - `lane_a`/`lane_b` = latched elements `[pass*laneCount +: laneCount]`; `alu_op` = latched op.
  - Each edge: write `lane_result` into `vect_out` at the same slice; neg_acc |= OR(`lane_neg`); zero_acc &= AND(`lane_zero`); pass++.
  - On pass == P-1 go to DONE; the counter does not wrap past P-1.
- DONE:
  - `result_valid`=1; `vect_out` is stable.
  - On `result_ready`: if latched `overwriteFlags`, then `NZ_flags` <= {zero_acc, neg_acc}; otherwise `NZ_flags` holds. Go to IDLE.
- Outside RUN, `lane_a`, `lane_b` and `alu_op` are driven to 0.
- `start_valid` is ignored outside IDLE; there is no queueing.
- `vect_out` retains its last result until it is overwritten slice by slice during the next RUN.
- Flag semantics: N = any element negative across the whole vector; Z = every element zero.

## Timing
- Reset values: state IDLE, `start_ready`=1, `busy`=0, `result_valid`=0, `vect_out`=0, `NZ_flags`=2'b00, `alu_op`/`lane_a`/`lane_b`=0, counter=0.
- Request accepted at edge T → RUN occupies cycles T+1..T+P → `result_valid` high from cycle T+P+1.
- Back-to-back rate: one request per P+2 cycles when `result_ready` is held high.
- P = 1: exactly one RUN cycle.
- `result_ready` held low: DONE holds indefinitely; outputs and flags are unchanged.
- `reset` during RUN or DONE: abandon the request immediately (asynchronously); outputs return to reset values; `NZ_flags` is cleared, not committed.
- `NZ_flags` changes only on the DONE→IDLE handshake edge, or on reset.

## Structure
- Shared package `vector_exec_pkg`:
  - state enum `seq_state_t` {IDLE, RUN, DONE}
  - NZ bit index constants `NZ_N=0`, `NZ_Z=1`
  - `opWidth` default
- One sub-module, `nz_flag_accumulator`:
  - takes `lane_neg`, `lane_zero` and clear/enable inputs
  - holds neg_acc/zero_acc
- The slice mux and write-back are implemented inline in the sequencer.

## Test plan
- Defaults (P=4), bench ALU model = add; vect1 all 1, vect2 all 2, overwriteFlags=1, `result_ready`=1 → `vect_out` all 3, `result_valid` at T+5, `NZ_flags`=2'b00, `start_ready` low for exactly 5 cycles.
- Subtract with vect1=vect2 all 7 → all elements 0, `NZ_flags`=2'b10. Repeat with element 13 of vect1 = 6 → element 13 = 0xFF, `NZ_flags`=2'b01. This checks Z across passes and N set only in the last slice.
- overwriteFlags=0 after a run that produced 2'b10, with a negative result → `NZ_flags` stays 2'b10; `vect_out` is updated.
- `result_ready` held low 10 cycles in DONE, and `start_valid` pulsed meanwhile → `result_valid` stays high, the second request is not accepted, and flags are unchanged until the handshake.
- `reset` asserted in the 2nd RUN cycle → same cycle: `busy`=0, `NZ_flags`=0, `vect_out`=0; the next request completes normally.
- Parameter variant laneCount=16 (P=1) → `result_valid` at T+2 with a correct full vector.
